// File: rtl/comp_seq_arbiter.sv
// comp_seq_arbiter: two-requester round-robin front end for a serial magnitude
// comparator that resolves two bits per cycle from the MSB pair downward.
module comp_seq_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic             rsp_eq,
    output logic             rsp_lt,
    output logic             rsp_gt,
    output logic             busy
);
    localparam int NP = WIDTH / 2;
    localparam int IW = NP > 1 ? $clog2(NP) : 1;

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]    idx;
    logic             id_q, ptr;
    logic             win0, acc, decide;
    logic [1:0]       ap, bp;

    // ptr holds the last granted id; on a tie the other requester wins
    assign win0       = req0_valid && (!req1_valid || ptr);
    assign req0_ready = rst_n && state == IDLE && win0;
    assign req1_ready = rst_n && state == IDLE && req1_valid && !win0;
    assign acc        = req0_ready || req1_ready;
    assign ap         = 2'(a_q >> {idx, 1'b0});
    assign bp         = 2'(b_q >> {idx, 1'b0});
    assign decide     = ap != bp || idx == '0;
    assign rsp_valid  = state == DONE;
    assign busy       = state != IDLE;

    always_comb begin
        state_d = state == IDLE ? (acc ? CMP : IDLE) :
                  state == CMP  ? (decide ? DONE : CMP) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            idx    <= '0;
            id_q   <= 1'b0;
            ptr    <= 1'b1;
            rsp_id <= 1'b0;
            rsp_eq <= 1'b0;
            rsp_lt <= 1'b0;
            rsp_gt <= 1'b0;
        end else begin
            state <= state_d;
            if (acc) begin
                a_q  <= req1_ready ? req1_a : req0_a;
                b_q  <= req1_ready ? req1_b : req0_b;
                id_q <= req1_ready;
                ptr  <= req1_ready;
                idx  <= IW'(NP - 1);
            end
            if (state == CMP && decide) begin
                rsp_id <= id_q;
                rsp_eq <= ap == bp;
                rsp_lt <= ap < bp;
                rsp_gt <= ap > bp;
            end else if (state == CMP) begin
                idx <= idx - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_comp_seq_arbiter.sv
// tb_comp_seq_arbiter: randomized and directed checks of the shared serial
// comparator against a plain-arithmetic reference of result, latency and grants.
module tb_comp_seq_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_gt, busy;
    logic       d2_valid, d2_ready, d2_r1ready, d2_rsp_valid, d2_id, d2_eq, d2_lt, d2_gt, d2_busy;
    logic [1:0] d2_a, d2_b;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    comp_seq_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_eq(rsp_eq), .rsp_lt(rsp_lt),
        .rsp_gt(rsp_gt), .busy(busy)
    );

    comp_seq_arbiter #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(d2_valid), .req0_ready(d2_ready), .req0_a(d2_a), .req0_b(d2_b),
        .req1_valid(1'b0), .req1_ready(d2_r1ready), .req1_a(2'b00), .req1_b(2'b00),
        .rsp_valid(d2_rsp_valid), .rsp_id(d2_id), .rsp_eq(d2_eq), .rsp_lt(d2_lt),
        .rsp_gt(d2_gt), .busy(d2_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Cycles from the accept cycle to the response: one per pair examined, plus DONE
    function automatic int exp_lat(input int w, input logic [31:0] a, input logic [31:0] b);
        int np = w / 2;
        for (int k = np - 1; k >= 0; k--)
            if (((a >> (2 * k)) & 3) != ((b >> (2 * k)) & 3)) return np - k + 1;
        return np + 1;
    endfunction

    always @(negedge clk) begin
        check("ready_excl", {31'd0, req0_ready & req1_ready}, 0);
        check("ready_busy", {31'd0, busy & (req0_ready | req1_ready)}, 0);
    end

    task automatic set_req(input bit id, input bit v, input logic [7:0] a, input logic [7:0] b);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b;
        end
    endtask

    task automatic wait_ready(input bit id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            ok = id ? req1_ready : req0_ready;
            if (ok) break;
            @(negedge clk);
        end
        check("accept", {31'd0, ok}, 1);
    endtask

    task automatic wait_rsp(input bit id, input logic [7:0] a, input logic [7:0] b);
        int lat = 0;
        bit seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            seen = rsp_valid;
            if (!seen) check("busy", {31'd0, busy}, 1);
        end
        check("latency", lat, exp_lat(8, a, b));
        check("rsp_id", {31'd0, rsp_id}, {31'd0, id});
        check("rsp_flags", {rsp_eq, rsp_lt, rsp_gt}, {a == b, a < b, a > b});
        @(negedge clk);
        check("pulse_len", {31'd0, rsp_valid}, 0);
        check("hold", {rsp_id, rsp_eq, rsp_lt, rsp_gt}, {id, a == b, a < b, a > b});
    endtask

    task automatic run_op(input bit id, input logic [7:0] a, input logic [7:0] b);
        bit ok;
        set_req(id, 1'b1, a, b);
        wait_ready(id, ok);
        @(posedge clk);
        #1;
        set_req(id, 1'b0, 8'($urandom), 8'($urandom));
        wait_rsp(id, a, b);
    endtask

    initial begin
        logic [7:0] oa[2], ob[2];
        logic [7:0] ca, cb, a, b;
        bit         g, ok, seen;
        int         lat;
        rst_n = 1'b0;
        set_req(0, 1'b1, 8'h00, 8'h00);
        set_req(1, 1'b1, 8'h00, 8'h00);
        d2_valid = 1'b0; d2_a = 2'b00; d2_b = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_outs", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_gt, busy}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 8'hA5, 8'hA5);
        run_op(1, 8'h80, 8'h7F);
        run_op(0, 8'h12, 8'h13);

        // Alternating grants from a fresh reset with both requesters always valid
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            oa[i] = 8'($urandom); ob[i] = 8'($urandom);
            set_req(i[0], 1'b1, oa[i], ob[i]);
        end
        g = 1'b0;
        for (int n = 0; n < 8; n++) begin
            wait_ready(g, ok);
            check("grant_other", {31'd0, g ? req0_ready : req1_ready}, 0);
            ca = oa[g]; cb = ob[g];
            @(posedge clk);
            #1;
            oa[g] = 8'($urandom); ob[g] = 8'($urandom);
            set_req(g, 1'b1, oa[g], ob[g]);
            wait_rsp(g, ca, cb);
            g = !g;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom);
            case ($urandom % 3)
                0: b = a;
                1: b = a ^ (8'd1 << ($urandom % 8));
                default: b = 8'($urandom);
            endcase
            run_op(1'($urandom), a, b);
        end

        // Abort during the second CMP cycle of an all-equal compare
        set_req(0, 1'b1, 8'hFF, 8'hFF);
        wait_ready(0, ok);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("abort_outs", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_gt, busy}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_rsp", {31'd0, rsp_valid | busy}, 0);
        end
        set_req(0, 1'b1, 8'h3C, 8'h3D);
        set_req(1, 1'b1, 8'h55, 8'h55);
        #1;
        check("post_rst_grant", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(0, 8'h3C, 8'h3D);

        // Single-pair instance: every operand combination decides in one CMP cycle
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                d2_a = 2'(x); d2_b = 2'(y); d2_valid = 1'b1;
                ok = 1'b0;
                for (int i = 0; i < 10 && !ok; i++) begin
                    #1;
                    ok = d2_ready;
                    if (!ok) @(negedge clk);
                end
                check("w2_accept", {31'd0, ok}, 1);
                @(posedge clk);
                #1;
                d2_valid = 1'b0;
                lat = 0; seen = 1'b0;
                while (!seen && lat < 10) begin
                    @(negedge clk);
                    lat++;
                    seen = d2_rsp_valid;
                end
                check("w2_latency", lat, 2);
                check("w2_flags", {d2_eq, d2_lt, d2_gt, d2_id, d2_r1ready, d2_busy}, {x == y, x < y, x > y, 3'b001});
                @(negedge clk);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
